fetch_pc_ifid: RTL and testbench

Fetch-stage state block for the RV32I five-stage pipeline. It holds the program counter (PCF) and selects the next PC from the sequential PCPlus4F value or the Execute-stage redirect target. It also implements the IF/ID pipeline register that carries the fetched instruction, PCF and PCPlus4F into Decode. Stall, flush and redirect inputs come from the hazard unit and Execute stage. PCF drives both the PC adder and instruction memory.

---
 rtl/rv32i_pkg.sv | 14 +
 rtl/pipe_reg_en_clr.sv | 24 ++
 rtl/fetch_pc_ifid.sv | 75 +++++++
 tb/tb_fetch_pc_ifid.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline constants and the IF/ID bundle type, reused by later
// pipeline registers.
package rv32i_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;
endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline flop: async active-low reset, synchronous clear (wins over
// enable), and enable.
module pipe_reg_en_clr #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     data_q <= RST_VAL;
        else if (clr_i) data_q <= CLR_VAL;
        else if (en_i)  data_q <= d_i;
    end

    assign q_o = data_q;
endmodule

// File: rtl/fetch_pc_ifid.sv
// Fetch-stage PC register with redirect/stall select, misaligned-target flag,
// and the IF/ID pipeline register feeding Decode.
module fetch_pc_ifid
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = rv32i_pkg::RESET_PC,
    parameter logic [31:0]     NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PCPlus4F,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            PCSrcE,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic [31:0]     InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            MisalignE
);
    localparam int    IFID_W   = $bits(ifid_t);
    localparam ifid_t IFID_NOP = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

    logic [XLEN-1:0] pc_d;
    logic            pc_en;
    ifid_t           ifid_d, ifid_q;
    logic            misalign_q;

    // Redirect overrides StallF so a taken branch is never dropped.
    assign pc_en = PCSrcE | ~StallF;
    assign pc_d  = PCSrcE ? {PCTargetE[XLEN-1:2], 2'b00} : PCPlus4F;

    pipe_reg_en_clr #(
        .W       (XLEN),
        .RST_VAL (RESET_PC),
        .CLR_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (pc_en),
        .clr_i (1'b0),
        .d_i   (pc_d),
        .q_o   (PCF)
    );

    assign ifid_d = '{instr: InstrF, pc: PCF, pc_plus4: PCPlus4F, valid: 1'b1};

    pipe_reg_en_clr #(
        .W       (IFID_W),
        .RST_VAL (IFID_NOP),
        .CLR_VAL (IFID_NOP)
    ) u_ifid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (~StallD),
        .clr_i (FlushD),
        .d_i   (ifid_d),
        .q_o   (ifid_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= PCSrcE & (PCTargetE[1:0] != 2'b00);
    end

    assign InstrD    = ifid_q.instr;
    assign PCD       = ifid_q.pc;
    assign PCPlus4D  = ifid_q.pc_plus4;
    assign ValidD    = ifid_q.valid;
    assign MisalignE = misalign_q;
endmodule

// File: tb/tb_fetch_pc_ifid.sv
// Self-checking bench for fetch_pc_ifid: directed vector table, randomized run
// against a behavioural model, and asynchronous reset corner cases.
module tb_fetch_pc_ifid;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCPlus4F, PCTargetE, InstrF;
    logic        PCSrcE, StallF, StallD, FlushD;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD, MisalignE;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External PC adder.
    assign PCPlus4F = PCF + 32'd4;

    fetch_pc_ifid dut (
        .clk(clk), .rst_n(rst_n),
        .PCPlus4F(PCPlus4F), .PCTargetE(PCTargetE), .PCSrcE(PCSrcE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .InstrF(InstrF),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .MisalignE(MisalignE)
    );

    typedef struct {
        logic        pcsrc;
        logic [31:0] target;
        logic        sf, sd, fd;
        logic [31:0] instr;
        logic [31:0] e_pc, e_instr, e_pcd, e_p4d;
        logic        e_valid, e_mis;
    } vec_t;

    vec_t vecs[15];

    // Behavioural model state.
    logic [31:0] m_pc, m_instr, m_pcd, m_p4d;
    logic        m_valid, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] pcd, input logic [31:0] p4d,
                           input logic v, input logic mis);
        chk({tag, ".PCF"}, PCF, pc);
        chk({tag, ".InstrD"}, InstrD, ins);
        chk({tag, ".PCD"}, PCD, pcd);
        chk({tag, ".PCPlus4D"}, PCPlus4D, p4d);
        chk({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, v});
        chk({tag, ".MisalignE"}, {31'd0, MisalignE}, {31'd0, mis});
    endtask

    task automatic drive(input logic pcsrc, input logic [31:0] t, input logic sf,
                         input logic sd, input logic fd, input logic [31:0] ins);
        PCSrcE = pcsrc; PCTargetE = t; StallF = sf; StallD = sd; FlushD = fd; InstrF = ins;
    endtask

    // Model of one rising edge, from the rules in plain arithmetic.
    task automatic model_edge();
        logic [31:0] cur_pc;
        cur_pc = m_pc;
        m_mis  = PCSrcE && (PCTargetE % 4 != 0);
        if (PCSrcE)       m_pc = PCTargetE - (PCTargetE % 4);
        else if (!StallF) m_pc = cur_pc + 4;
        if (FlushD) begin
            m_instr = 32'h13; m_pcd = 0; m_p4d = 0; m_valid = 0;
        end else if (!StallD) begin
            m_instr = InstrF; m_pcd = cur_pc; m_p4d = cur_pc + 4; m_valid = 1;
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 32'h13; m_pcd = 0; m_p4d = 0; m_valid = 0; m_mis = 0;
    endtask

    function automatic vec_t mk(input logic pcsrc, input logic [31:0] t, input logic sf,
                                input logic sd, input logic fd, input logic [31:0] ins,
                                input logic [31:0] pc, input logic [31:0] ei,
                                input logic [31:0] pd, input logic [31:0] p4,
                                input logic v, input logic mis);
        vec_t r;
        r.pcsrc = pcsrc; r.target = t; r.sf = sf; r.sd = sd; r.fd = fd; r.instr = ins;
        r.e_pc = pc; r.e_instr = ei; r.e_pcd = pd; r.e_p4d = p4; r.e_valid = v; r.e_mis = mis;
        return r;
    endfunction

    initial begin
        //              src target        sf sd fd instr          PCF          InstrD       PCD          PCPlus4D     V  Mis
        vecs[0]  = mk(0, 32'h0,        0, 0, 0, 32'h0050_0093, 32'h4,       32'h0050_0093, 32'h0,     32'h4,       1, 0);
        vecs[1]  = mk(0, 32'h0,        0, 0, 0, 32'h0050_0093, 32'h8,       32'h0050_0093, 32'h4,     32'h8,       1, 0);
        vecs[2]  = mk(0, 32'h0,        0, 0, 0, 32'h0010_0113, 32'hC,       32'h0010_0113, 32'h8,     32'hC,       1, 0);
        vecs[3]  = mk(1, 32'h10,       0, 0, 1, 32'hDEAD_BEEF, 32'h10,      32'h13,        32'h0,     32'h0,       0, 0);
        vecs[4]  = mk(0, 32'h0,        0, 0, 0, 32'h1111_1111, 32'h14,      32'h1111_1111, 32'h10,    32'h14,      1, 0);
        vecs[5]  = mk(0, 32'h0,        1, 1, 0, 32'h2222_2222, 32'h14,      32'h1111_1111, 32'h10,    32'h14,      1, 0);
        vecs[6]  = mk(0, 32'h0,        1, 1, 0, 32'h2222_2222, 32'h14,      32'h1111_1111, 32'h10,    32'h14,      1, 0);
        vecs[7]  = mk(1, 32'h40,       1, 0, 1, 32'h2222_2222, 32'h40,      32'h13,        32'h0,     32'h0,       0, 0);
        vecs[8]  = mk(1, 32'h42,       0, 0, 0, 32'h0000_0033, 32'h40,      32'h33,        32'h40,    32'h44,      1, 1);
        vecs[9]  = mk(0, 32'h0,        0, 0, 0, 32'h0000_0044, 32'h44,      32'h44,        32'h40,    32'h44,      1, 0);
        vecs[10] = mk(0, 32'h0,        0, 1, 1, 32'h0000_0099, 32'h48,      32'h13,        32'h0,     32'h0,       0, 0);
        vecs[11] = mk(0, 32'h0,        1, 0, 0, 32'h0000_0055, 32'h48,      32'h55,        32'h48,    32'h4C,      1, 0);
        vecs[12] = mk(0, 32'h0,        1, 0, 0, 32'h0000_0056, 32'h48,      32'h56,        32'h48,    32'h4C,      1, 0);
        vecs[13] = mk(1, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_0066, 32'hFFFF_FFFC, 32'h66,      32'h48,    32'h4C,      1, 1);
        vecs[14] = mk(0, 32'h0,        0, 0, 0, 32'h0000_0077, 32'h0,       32'h77,        32'hFFFF_FFFC, 32'h0,   1, 0);

        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_all("reset", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].pcsrc, vecs[i].target, vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].instr);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pcd,
                    vecs[i].e_p4d, vecs[i].e_valid, vecs[i].e_mis);
        end

        // Misalign pulse clears once the condition goes away.
        drive(0, 32'h3, 0, 0, 0, 32'h88);
        @(negedge clk);
        chk("mis_clear", {31'd0, MisalignE}, 32'd0);

        // Randomized run against the model, starting from a fresh reset.
        rst_n = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            logic src;
            src = ($urandom_range(0, 5) == 0);
            drive(src, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  src ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0), $urandom);
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk_all($sformatf("rnd%0d", c), m_pc, m_instr, m_pcd, m_p4d, m_valid, m_mis);
        end

        // Reach PCF=0x80 with a valid Decode, then reset mid-stall/redirect without a clock edge.
        drive(1, 32'h7C, 0, 0, 1, 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 0, 0, 0, 32'h0AB0_0093);
        @(negedge clk);
        chk("pre_rst.PCF", PCF, 32'h80);
        chk("pre_rst.ValidD", {31'd0, ValidD}, 32'd1);
        drive(1, 32'h102, 1, 1, 0, 32'h1234);
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("rst_hold", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 0, 32'h0050_0093);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("rst_release", 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
